// File: rtl/dmni_br_ctrl_pkg.sv
// Shared definitions for the DMNI BrLite service controller: MMR offsets, IRQ bits, FIFO entry layouts.
// DMNI_BR_TIMESTAMP_EN adds a 32-bit receive timestamp to each RX entry.
package dmni_br_ctrl_pkg;

  localparam int unsigned BR_KSVC_W    = 4;
  localparam int unsigned BR_PAYLOAD_W = 16;
  localparam int unsigned BR_SEQ_W     = 16;
  localparam int unsigned BR_TS_W      = 32;

  localparam logic [7:0] MMR_STATUS       = 8'h00;
  localparam logic [7:0] MMR_IRQ_STAT     = 8'h04;
  localparam logic [7:0] MMR_IRQ_MASK     = 8'h08;
  localparam logic [7:0] MMR_TX_PAYLOAD   = 8'h0C;
  localparam logic [7:0] MMR_TX_KSVC      = 8'h10;
  localparam logic [7:0] MMR_RX_KSVC      = 8'h14;
  localparam logic [7:0] MMR_RX_PAYLOAD   = 8'h18;
  localparam logic [7:0] MMR_RX_TIMESTAMP = 8'h1C;

  localparam int unsigned IRQ_W        = 3;
  localparam int unsigned IRQ_RX_AVAIL = 0;
  localparam int unsigned IRQ_TX_DONE  = 1;
  localparam int unsigned IRQ_TX_OVF   = 2;

  typedef struct packed {
    logic [BR_KSVC_W-1:0]    ksvc;
    logic [BR_PAYLOAD_W-1:0] payload;
  } br_tx_entry_t;

  typedef struct packed {
    logic [BR_KSVC_W-1:0]    ksvc;
    logic [BR_SEQ_W-1:0]     seq;
    logic [BR_PAYLOAD_W-1:0] payload;
`ifdef DMNI_BR_TIMESTAMP_EN
    logic [BR_TS_W-1:0]      ts;
`endif
  } br_rx_entry_t;

endpackage

// File: rtl/dmni_br_ctrl_br_fifo.sv
// Synchronous FIFO with registered count; push is refused when full, pop when empty.
// DEPTH must be a power of two so pointers wrap naturally.
module br_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_c, pop_ok_c;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign push_ok_c = push_i && !full_o;
  assign pop_ok_c  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok_c && !pop_ok_c)      count_d = count_q + CW'(1);
    else if (pop_ok_c && !push_ok_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_c) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dmni_br_ctrl.sv
// BrLite service controller for the DMNI: MMR front-end, TX/RX FIFOs and maskable IRQ.
// Define DMNI_BR_TIMESTAMP_EN to capture timestamp_i with each received message.
module dmni_br_ctrl
  import dmni_br_ctrl_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RX_DEPTH  = 4,
  parameter int unsigned KSVC_W    = BR_KSVC_W,
  parameter int unsigned PAYLOAD_W = BR_PAYLOAD_W,
  parameter int unsigned SEQ_W     = BR_SEQ_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_en_i,
  input  logic [3:0]           cfg_we_i,
  input  logic [7:0]           cfg_addr_i,
  input  logic [31:0]          cfg_data_i,
  output logic [31:0]          cfg_data_o,
  output logic                 irq_o,
  output logic                 br_req_o,
  input  logic                 br_ack_i,
  output logic [KSVC_W-1:0]    br_ksvc_o,
  output logic [PAYLOAD_W-1:0] br_payload_o,
  input  logic                 br_rx_i,
  output logic                 br_ack_o,
  input  logic [KSVC_W-1:0]    br_ksvc_i,
  input  logic [SEQ_W-1:0]     br_seq_i,
  input  logic [PAYLOAD_W-1:0] br_payload_i,
  input  logic [31:0]          timestamp_i
);

  localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

  logic [31:0]        cfg_data_q, cfg_data_d;
  logic [15:0]        staging_q, staging_d;
  logic [IRQ_W-1:0]   irq_mask_q, irq_mask_d;
  logic               tx_done_q, tx_done_d;
  logic               tx_ovf_q, tx_ovf_d;
  logic               br_ack_q, br_ack_d;

  logic               rd_c, wr_c;
  logic [31:0]        rd_data_c;
  logic [IRQ_W-1:0]   irq_stat_c;
  logic               tx_push_c, tx_pop_c, tx_full, tx_empty;
  logic               tx_done_set_c, tx_done_clr_c, tx_ovf_clr_c;
  logic               rx_push_c, rx_pop_c, rx_full, rx_empty;
  logic [TX_CNT_W-1:0] tx_count;
  logic [RX_CNT_W-1:0] rx_count;
  br_tx_entry_t       tx_in, tx_head;
  br_rx_entry_t       rx_in, rx_head;
  logic               unused_c;

  assign rd_c = cfg_en_i && (cfg_we_i == 4'h0);
  assign wr_c = cfg_en_i && (cfg_we_i != 4'h0);

  // TX path: CPU pushes via TX_KSVC, BrLite pops on req && ack
  assign tx_push_c     = wr_c && (cfg_addr_i == MMR_TX_KSVC) && cfg_we_i[0];
  assign tx_pop_c      = br_req_o && br_ack_i;
  assign tx_in.ksvc    = BR_KSVC_W'(cfg_data_i[KSVC_W-1:0]);
  assign tx_in.payload = BR_PAYLOAD_W'(staging_q);

  br_fifo #(
    .WIDTH ($bits(br_tx_entry_t)),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_push_c),
    .data_i  (tx_in),
    .pop_i   (tx_pop_c),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // RX path: capture only when not acknowledging, so acks are never back to back
  assign rx_push_c     = br_rx_i && !br_ack_q && !rx_full;
  assign rx_pop_c      = rd_c && (cfg_addr_i == MMR_RX_KSVC) && !rx_empty;
  assign rx_in.ksvc    = BR_KSVC_W'(br_ksvc_i);
  assign rx_in.seq     = BR_SEQ_W'(br_seq_i);
  assign rx_in.payload = BR_PAYLOAD_W'(br_payload_i);
`ifdef DMNI_BR_TIMESTAMP_EN
  assign rx_in.ts      = timestamp_i;
  assign unused_c      = ^cfg_data_i[31:16];
`else
  assign unused_c      = ^{cfg_data_i[31:16], timestamp_i};
`endif

  br_fifo #(
    .WIDTH ($bits(br_rx_entry_t)),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push_c),
    .data_i  (rx_in),
    .pop_i   (rx_pop_c),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign irq_stat_c[IRQ_RX_AVAIL] = !rx_empty;
  assign irq_stat_c[IRQ_TX_DONE]  = tx_done_q;
  assign irq_stat_c[IRQ_TX_OVF]   = tx_ovf_q;

  assign tx_done_clr_c = wr_c && (cfg_addr_i == MMR_IRQ_STAT) && cfg_we_i[0] && cfg_data_i[IRQ_TX_DONE];
  assign tx_ovf_clr_c  = wr_c && (cfg_addr_i == MMR_IRQ_STAT) && cfg_we_i[0] && cfg_data_i[IRQ_TX_OVF];
  // Only a pop that is not backfilled by a same-cycle push leaves TX empty
  assign tx_done_set_c = tx_pop_c && (tx_count == TX_CNT_W'(1)) && !(tx_push_c && !tx_full);

  always_comb begin
    rd_data_c = '0;
    case (cfg_addr_i)
      MMR_STATUS:       rd_data_c = {8'h00, 8'(rx_count), 8'(tx_count), 5'h00,
                                     tx_empty, tx_full, !rx_empty};
      MMR_IRQ_STAT:     rd_data_c = 32'(irq_stat_c);
      MMR_IRQ_MASK:     rd_data_c = 32'(irq_mask_q);
      MMR_TX_PAYLOAD:   rd_data_c = 32'(staging_q);
      MMR_RX_KSVC:      if (!rx_empty) rd_data_c = 32'h0000_0100 | 32'(rx_head.ksvc);
      MMR_RX_PAYLOAD:   rd_data_c = 32'({rx_head.seq, rx_head.payload});
`ifdef DMNI_BR_TIMESTAMP_EN
      MMR_RX_TIMESTAMP: rd_data_c = 32'(rx_head.ts);
`else
      MMR_RX_TIMESTAMP: rd_data_c = '0;
`endif
      default:          rd_data_c = '0;
    endcase
  end

  always_comb begin
    cfg_data_d = cfg_data_q;
    staging_d  = staging_q;
    irq_mask_d = irq_mask_q;
    tx_done_d  = tx_done_q;
    tx_ovf_d   = tx_ovf_q;
    br_ack_d   = rx_push_c;
    if (rd_c) cfg_data_d = rd_data_c;
    if (wr_c && (cfg_addr_i == MMR_TX_PAYLOAD)) begin
      if (cfg_we_i[0]) staging_d[7:0]  = cfg_data_i[7:0];
      if (cfg_we_i[1]) staging_d[15:8] = cfg_data_i[15:8];
    end
    if (wr_c && (cfg_addr_i == MMR_IRQ_MASK) && cfg_we_i[0]) irq_mask_d = cfg_data_i[IRQ_W-1:0];
    // Clear first, then set, so a coincident set wins
    if (tx_done_clr_c) tx_done_d = 1'b0;
    if (tx_done_set_c) tx_done_d = 1'b1;
    if (tx_ovf_clr_c)  tx_ovf_d  = 1'b0;
    if (tx_push_c && tx_full) tx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_data_q <= '0;
      staging_q  <= '0;
      irq_mask_q <= '0;
      tx_done_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      br_ack_q   <= 1'b0;
    end else begin
      cfg_data_q <= cfg_data_d;
      staging_q  <= staging_d;
      irq_mask_q <= irq_mask_d;
      tx_done_q  <= tx_done_d;
      tx_ovf_q   <= tx_ovf_d;
      br_ack_q   <= br_ack_d;
    end
  end

  assign cfg_data_o   = cfg_data_q;
  assign br_ack_o     = br_ack_q;
  assign irq_o        = |(irq_stat_c & irq_mask_q);
  assign br_req_o     = !tx_empty;
  assign br_ksvc_o    = tx_empty ? '0 : KSVC_W'(tx_head.ksvc);
  assign br_payload_o = tx_empty ? '0 : PAYLOAD_W'(tx_head.payload);

endmodule

// File: tb/tb_dmni_br_ctrl.sv
// Scoreboard bench for dmni_br_ctrl: reads and TX drains are checked by a monitor against queued expectations.
module tb_dmni_br_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [3:0]  cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_data_o;
  logic        irq_o, br_req_o, br_ack_i, br_rx_i, br_ack_o;
  logic [3:0]  br_ksvc_o, br_ksvc_i;
  logic [15:0] br_payload_o, br_payload_i, br_seq_i;
  logic [31:0] timestamp_i;

  always #5 clk = ~clk;

  dmni_br_ctrl #(
    .TX_DEPTH(4), .RX_DEPTH(4), .KSVC_W(4), .PAYLOAD_W(16), .SEQ_W(16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_en_i     (cfg_en),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_data_i   (cfg_wdata),
    .cfg_data_o   (cfg_data_o),
    .irq_o        (irq_o),
    .br_req_o     (br_req_o),
    .br_ack_i     (br_ack_i),
    .br_ksvc_o    (br_ksvc_o),
    .br_payload_o (br_payload_o),
    .br_rx_i      (br_rx_i),
    .br_ack_o     (br_ack_o),
    .br_ksvc_i    (br_ksvc_i),
    .br_seq_i     (br_seq_i),
    .br_payload_i (br_payload_i),
    .timestamp_i  (timestamp_i)
  );

  localparam logic [7:0] A_STATUS = 8'h00, A_IRQ_STAT = 8'h04, A_IRQ_MASK = 8'h08,
                         A_TX_PAY = 8'h0C, A_TX_KSVC = 8'h10, A_RX_KSVC = 8'h14,
                         A_RX_PAY = 8'h18, A_RX_TS = 8'h1C;

  int          n_vec = 0;
  int          n_err = 0;
  int          ack_cnt = 0;
  int          msg_idx = 0;
  int          msg_lim = 0;
  bit          prev_ack = 1'b0;
  bit          rd_seen = 1'b0;
  logic [31:0] exp_rd_q[$];
  string       exp_nm_q[$];
  logic [19:0] exp_tx_q[$];
  logic [31:0] mon_exp;
  string       mon_nm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ts(input logic [31:0] v);
`ifdef DMNI_BR_TIMESTAMP_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  // Monitor: read data one cycle after a read strobe, TX entries on each req&&ack, ack spacing
  always @(posedge clk) rd_seen <= rst_n && cfg_en && (cfg_we == 4'h0);

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rd_scoreboard: unexpected read data 0x%08h", cfg_data_o);
      end else begin
        mon_exp = exp_rd_q.pop_front();
        mon_nm  = exp_nm_q.pop_front();
        check(mon_nm, cfg_data_o, mon_exp);
      end
    end
    if (rst_n && br_req_o && br_ack_i) begin
      if (exp_tx_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL tx_scoreboard: unexpected drain ksvc=0x%0h payload=0x%04h", br_ksvc_o, br_payload_o);
      end else begin
        check("tx_drain", {12'h0, br_ksvc_o, br_payload_o}, {12'h0, exp_tx_q.pop_front()});
      end
    end
    if (br_ack_o) begin
      ack_cnt++;
      check("ack_gap", 32'(prev_ack), 32'h0);
    end
    prev_ack = br_ack_o;
  end

  task automatic cfg_write(input logic [7:0] addr, input logic [3:0] we, input logic [31:0] data);
    cfg_en = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_we = 4'h0;
  endtask

  task automatic cfg_read(input string name, input logic [7:0] addr, input logic [31:0] exp);
    exp_rd_q.push_back(exp);
    exp_nm_q.push_back(name);
    cfg_en = 1'b1; cfg_we = 4'h0; cfg_addr = addr;
    @(posedge clk); #1;
    cfg_en = 1'b0;
  endtask

  task automatic tx_push(input logic [3:0] k, input logic [15:0] p, input bit accepted);
    cfg_write(A_TX_PAY, 4'h3, 32'(p));
    cfg_write(A_TX_KSVC, 4'h1, 32'(k));
    if (accepted) exp_tx_q.push_back({k, p});
  endtask

  task automatic drive_msg();
    br_ksvc_i    = 4'(msg_idx + 5);
    br_seq_i     = 16'hA000 + 16'(msg_idx);
    br_payload_i = 16'h5000 + 16'(msg_idx);
    timestamp_i  = 32'h1234 + 32'(msg_idx);
    br_rx_i      = (msg_idx < msg_lim);
  endtask

  // Router model: advance to the next message once the previous one was acknowledged
  task automatic router_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (br_ack_o) begin
        msg_idx++;
        drive_msg();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_we = 4'h0; cfg_addr = 8'h0; cfg_wdata = '0;
    br_ack_i = 1'b0; br_rx_i = 1'b0; br_ksvc_i = '0; br_seq_i = '0; br_payload_i = '0;
    timestamp_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_req", 32'(br_req_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_ack", 32'(br_ack_o), 32'h0);
    check("rst_cfg_data", cfg_data_o, 32'h0);
    cfg_read("rst_status", A_STATUS, 32'h0000_0004);

    // Single TX request
    tx_push(4'h3, 16'hBEEF, 1'b1);
    check("tx1_req", 32'(br_req_o), 32'h1);
    check("tx1_head", {12'h0, br_ksvc_o, br_payload_o}, 32'h0003_BEEF);
    cfg_read("tx_staging", A_TX_PAY, 32'h0000_BEEF);
    br_ack_i = 1'b1;
    @(posedge clk); #1;
    br_ack_i = 1'b0;
    check("tx1_req_after", 32'(br_req_o), 32'h0);
    cfg_read("tx1_done", A_IRQ_STAT, 32'h0000_0002);
    check("tx1_irq_masked", 32'(irq_o), 32'h0);
    cfg_write(A_IRQ_STAT, 4'h1, 32'h2);
    cfg_read("tx1_w1c", A_IRQ_STAT, 32'h0);

    // Overflow: five pushes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) tx_push(4'(i), 16'h1000 + 16'(i), i <= 4);
    cfg_read("ovf_status", A_STATUS, 32'h0000_0402);
    cfg_read("ovf_stat", A_IRQ_STAT, 32'h0000_0004);
    check("ovf_irq_mask0", 32'(irq_o), 32'h0);
    cfg_write(A_IRQ_MASK, 4'h1, 32'h3);
    check("ovf_irq_mask3", 32'(irq_o), 32'h0);
    cfg_write(A_IRQ_MASK, 4'h1, 32'h4);
    check("ovf_irq_mask4", 32'(irq_o), 32'h1);
    cfg_read("mask_rd", A_IRQ_MASK, 32'h0000_0004);

    // Drain four entries; W1C of TX_DONE lands with the emptying pop
    br_ack_i = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    cfg_write(A_IRQ_STAT, 4'h1, 32'h2);
    br_ack_i = 1'b0;
    check("drain_req", 32'(br_req_o), 32'h0);
    cfg_read("done_set_wins", A_IRQ_STAT, 32'h0000_0006);
    cfg_write(A_IRQ_STAT, 4'h1, 32'h6);
    cfg_read("stat_cleared", A_IRQ_STAT, 32'h0);
    check("irq_cleared", 32'(irq_o), 32'h0);

    // RX backpressure: six messages offered into a four-entry FIFO
    cfg_write(A_IRQ_MASK, 4'h1, 32'h1);
    msg_idx = 0; msg_lim = 6; ack_cnt = 0;
    drive_msg();
    router_run(20);
    check("rx_acks_full", 32'(ack_cnt), 32'd4);
    check("rx_irq", 32'(irq_o), 32'h1);
    cfg_read("rx_status_full", A_STATUS, 32'h0004_0005);
    cfg_read("rx0_payload", A_RX_PAY, 32'hA000_5000);
    cfg_read("rx0_ts", A_RX_TS, exp_ts(32'h0000_1234));
    cfg_read("rx0_ksvc", A_RX_KSVC, 32'h0000_0105);
    cfg_read("rx_status_pop", A_STATUS, 32'h0003_0005);
    router_run(10);
    check("rx_acks_after_pop", 32'(ack_cnt), 32'd5);
    br_rx_i = 1'b0;
    cfg_read("rx_status_refill", A_STATUS, 32'h0004_0005);
    cfg_read("rx1_payload", A_RX_PAY, 32'hA001_5001);
    cfg_read("rx1_ts", A_RX_TS, exp_ts(32'h0000_1235));
    cfg_read("rx1_ksvc", A_RX_KSVC, 32'h0000_0106);
    cfg_read("rx2_ksvc", A_RX_KSVC, 32'h0000_0107);
    cfg_read("rx3_ksvc", A_RX_KSVC, 32'h0000_0108);
    cfg_read("rx4_payload", A_RX_PAY, 32'hA004_5004);
    cfg_read("rx4_ksvc", A_RX_KSVC, 32'h0000_0109);
    cfg_read("rx_empty_ksvc", A_RX_KSVC, 32'h0);
    cfg_read("rx_status_empty", A_STATUS, 32'h0000_0004);
    check("rx_irq_empty", 32'(irq_o), 32'h0);
    check("rx_acks_total", 32'(ack_cnt), 32'd5);

    // Reset with traffic queued in both directions
    tx_push(4'hA, 16'h7777, 1'b0);
    tx_push(4'hB, 16'h7777, 1'b0);
    tx_push(4'hC, 16'h7777, 1'b0);
    msg_idx = 10; msg_lim = 12;
    drive_msg();
    router_run(10);
    check("pre_rst_acks", 32'(ack_cnt), 32'd7);
    cfg_write(A_IRQ_MASK, 4'h1, 32'h7);
    cfg_read("pre_rst_status", A_STATUS, 32'h0002_0301);
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_req", 32'(br_req_o), 32'h0);
    check("post_rst_irq", 32'(irq_o), 32'h0);
    check("post_rst_cfg_data", cfg_data_o, 32'h0);
    check("post_rst_head", {12'h0, br_ksvc_o, br_payload_o}, 32'h0);
    cfg_read("post_rst_status", A_STATUS, 32'h0000_0004);
    cfg_read("post_rst_staging", A_TX_PAY, 32'h0);
    cfg_read("post_rst_mask", A_IRQ_MASK, 32'h0);
    cfg_write(8'h20, 4'hF, 32'hFFFF_FFFF);
    cfg_read("unmapped_rd", 8'h20, 32'h0);
    cfg_read("tx_ksvc_wo", A_TX_KSVC, 32'h0);

    @(negedge clk); #1;
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'h0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
